// File: rtl/dac_pkg.sv
// Shared definitions for the multi-channel serial DAC controller.
// Optional feature macro used by the controller: DAC_ADDR_PREFIX_EN.
package dac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        SHIFT,
        GAP,
        FIN
    } state_t;

    // DAC command nibble: write input register and update the output.
    localparam logic [3:0] DAC_CMD_WR_UPD = 4'h3;

    // Width of the command/address byte sent ahead of the data word.
    localparam int PREFIX_W = 8;

    // Ceiling log2, returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dac_shift_frame.sv
// Serialises one DAC frame: SCLK divider, MSB-first shift register and bit
// counter. The word is left-justified; the top len bits are sent.
// SCLK idles high, the DAC samples on the falling edge and SDI only moves
// together with a rising edge. frame_done marks the cycle whose clock edge
// produces the last rising SCLK edge of the frame.
module dac_shift_frame
    import dac_pkg::*;
#(
    parameter int FRAME_W = 16,
    parameter int CLK_DIV = 2,
    localparam int LEN_W  = clog2(FRAME_W + 1),
    localparam int DIV_W  = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               load,
    input  logic [LEN_W-1:0]   len,
    input  logic [FRAME_W-1:0] word,
    output logic               sclk,
    output logic               sdi,
    output logic               frame_done
);

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               sclk_q, sclk_d;
    logic               active_q, active_d;
    logic               half_done;

    // Divider, SCLK toggling and shifting; a new bit is presented on every
    // rising edge, and the rising edge that completes the last bit ends the frame.
    always_comb begin
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        len_d      = len_q;
        shreg_d    = shreg_q;
        sclk_d     = sclk_q;
        active_d   = active_q;
        frame_done = 1'b0;
        half_done  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        if (load) begin
            shreg_d   = word;
            len_d     = len;
            bit_cnt_d = '0;
            div_cnt_d = '0;
            sclk_d    = 1'b1;
            active_d  = 1'b1;
        end else if (active_q) begin
            if (half_done) begin
                div_cnt_d = '0;
                sclk_d    = ~sclk_q;
                if (!sclk_q) begin
                    if (bit_cnt_q == len_q - LEN_W'(1)) begin
                        frame_done = 1'b1;
                        active_d   = 1'b0;
                        shreg_d    = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + LEN_W'(1);
                        shreg_d   = {shreg_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Frame state registers; reset leaves SCLK at its high idle level.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            len_q     <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            active_q  <= active_d;
        end
    end

    assign sclk = sclk_q;
    assign sdi  = shreg_q[FRAME_W-1];

endmodule

// File: rtl/dac_ctrl_multi.sv
// Multi-channel serial DAC controller: latches CH_N words and a channel mask
// on an accepted start, then sends one SYNC frame per enabled channel in
// ascending channel order with a SYNC-high gap between frames.
// Optional feature macro: DAC_ADDR_PREFIX_EN (prefixes each frame with the
// write-and-update command nibble and the channel number).
module dac_ctrl_multi
    import dac_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CH_N    = 2,
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4,
    localparam int CH_W   = (CH_N > 1) ? clog2(CH_N) : 1
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CH_N*DATA_W-1:0] dato,
    input  logic [CH_N-1:0]        ch_mask,
    output logic                   busy,
    output logic                   done,
    output logic [CH_W-1:0]        cur_ch,
    output logic                   sync,
    output logic                   sclk,
    output logic                   sdi
);

`ifdef DAC_ADDR_PREFIX_EN
    localparam int FRAME_W = PREFIX_W + DATA_W;
`else
    localparam int FRAME_W = DATA_W;
`endif
    localparam int LEN_W    = clog2(FRAME_W + 1);
    localparam int SCAN_W   = clog2(CH_N + 1);
    localparam int GAP_W    = (GAP_CYC > 2) ? clog2(GAP_CYC - 1) : 1;
    // SEL is the last SYNC-high cycle between frames, so GAP itself runs
    // GAP_CYC-1 cycles and is skipped entirely when GAP_CYC is 1.
    localparam int GAP_LAST = (GAP_CYC > 2) ? GAP_CYC - 2 : 0;

`ifdef DAC_ADDR_PREFIX_EN
    // The channel number only has a 4-bit field in the prefix byte.
    generate
        if (CH_N > 16) begin : g_ch_n_check
            $error("dac_ctrl_multi: CH_N must be <= 16 with the address prefix enabled");
        end
    endgenerate
`endif

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic [CH_N*DATA_W-1:0]  dato_q, dato_d;
    logic [CH_N-1:0]         mask_q, mask_d;
    logic [SCAN_W-1:0]       scan_q, scan_d;
    logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    sel_found;
    logic [CH_W-1:0]         sel_idx;
    logic [DATA_W-1:0]       sel_word;
    logic [FRAME_W-1:0]      frame_word;
    logic                    load;
    logic                    frame_done;

    // Find the lowest enabled channel at or above the scan pointer; the
    // descending loop lets the lowest match win.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_word  = '0;
        for (int k = CH_N - 1; k >= 0; k--) begin
            if (mask_q[k] && (SCAN_W'(k) >= scan_q)) begin
                sel_found = 1'b1;
                sel_idx   = CH_W'(k);
                sel_word  = dato_q[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef DAC_ADDR_PREFIX_EN
    assign frame_word = {DAC_CMD_WR_UPD, 4'(sel_idx), sel_word};
`else
    assign frame_word = sel_word;
`endif

    // Channel sequencing and handshake; a start is taken whenever busy is low,
    // which includes the FIN cycle, so back-to-back requests need no idle cycle.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        dato_d   = dato_q;
        mask_d   = mask_q;
        scan_d   = scan_q;
        cur_ch_d = cur_ch_q;
        gap_d    = gap_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (busy_q) state_d = SEL;
            end
            SEL: begin
                if (sel_found) begin
                    cur_ch_d = sel_idx;
                    scan_d   = SCAN_W'(sel_idx) + SCAN_W'(1);
                    load     = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    busy_d  = 1'b0;
                    state_d = FIN;
                end
            end
            SHIFT: begin
                if (frame_done) begin
                    gap_d   = '0;
                    state_d = (GAP_CYC > 1) ? GAP : SEL;
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(GAP_LAST)) state_d = SEL;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start && !busy_q) begin
            busy_d = 1'b1;
            dato_d = dato;
            mask_d = ch_mask;
            scan_d = '0;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            dato_q   <= '0;
            mask_q   <= '0;
            scan_q   <= '0;
            cur_ch_q <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            dato_q   <= dato_d;
            mask_q   <= mask_d;
            scan_q   <= scan_d;
            cur_ch_q <= cur_ch_d;
            gap_q    <= gap_d;
        end
    end

    dac_shift_frame #(
        .FRAME_W (FRAME_W),
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk_in     (clk_in),
        .rst        (rst),
        .load       (load),
        .len        (LEN_W'(FRAME_W)),
        .word       (frame_word),
        .sclk       (sclk),
        .sdi        (sdi),
        .frame_done (frame_done)
    );

    assign busy   = busy_q;
    assign done   = (state_q == FIN);
    assign cur_ch = cur_ch_q;
    assign sync   = (state_q != SHIFT);

endmodule

// File: tb/tb_dac_ctrl_multi.sv
// Self-checking bench for dac_ctrl_multi: a default-parameter instance driven
// from a vector table, hand sequences and random requests, plus a
// DATA_W=24/CH_N=4/CLK_DIV=1 instance. Frames are captured on the serial pins
// and compared with a model built from the request (channel order, words,
// frame length, done latency).
module tb_dac_ctrl_multi;

    localparam int DATA_W  = 16;
    localparam int CH_N    = 2;
    localparam int CLK_DIV = 2;
    localparam int GAP_CYC = 4;
    localparam int D2_W    = 24;
    localparam int D2_CH   = 4;
    localparam int D2_DIV  = 1;
`ifdef DAC_ADDR_PREFIX_EN
    localparam int FRAME_BITS    = DATA_W + 8;
    localparam int D2_FRAME_BITS = D2_W + 8;
`else
    localparam int FRAME_BITS    = DATA_W;
    localparam int D2_FRAME_BITS = D2_W;
`endif
    localparam int FRAME_CYC    = 2 * CLK_DIV * FRAME_BITS;
    localparam int D2_FRAME_CYC = 2 * D2_DIV * D2_FRAME_BITS;
    localparam int WAIT_LIMIT   = 2000;

    typedef struct {
        int          ch;
        logic [63:0] word;
        int          falls;
        int          low;
    } frame_t;

    typedef struct {
        logic [31:0] dato;
        logic [1:0]  mask;
        int          exp_frames;
        int          exp_first_ch;
    } vec_t;

    logic clk;
    logic rst;
    logic start;
    logic [CH_N*DATA_W-1:0] dato;
    logic [CH_N-1:0] ch_mask;
    logic busy, done, sync, sclk, sdi;
    logic [0:0] cur_ch;

    logic start2;
    logic [D2_CH*D2_W-1:0] dato2;
    logic [D2_CH-1:0] mask2;
    logic busy2, done2, sync2, sclk2, sdi2;
    logic [1:0] cur_ch2;

    int checks = 0;
    int errors = 0;
    int stray  = 0;
    frame_t got_q[$];
    frame_t got2_q[$];
    frame_t exp_q[$];

    dac_ctrl_multi #(
        .DATA_W(DATA_W), .CH_N(CH_N), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk_in(clk), .rst(rst), .start(start), .dato(dato), .ch_mask(ch_mask),
        .busy(busy), .done(done), .cur_ch(cur_ch), .sync(sync), .sclk(sclk), .sdi(sdi)
    );

    dac_ctrl_multi #(
        .DATA_W(D2_W), .CH_N(D2_CH), .CLK_DIV(D2_DIV), .GAP_CYC(GAP_CYC)
    ) dut2 (
        .clk_in(clk), .rst(rst), .start(start2), .dato(dato2), .ch_mask(mask2),
        .busy(busy2), .done(done2), .cur_ch(cur_ch2), .sync(sync2), .sclk(sclk2), .sdi(sdi2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Capture frames on the first instance: SYNC-low length, SCLK falls and
    // the SDI bit seen at each fall. SCLK movement while SYNC is high is stray.
    logic prev_sync = 1'b1;
    logic prev_sclk = 1'b1;
    frame_t cur;
    always @(negedge clk) begin
        if (rst) begin
            prev_sync = 1'b1;
            prev_sclk = 1'b1;
        end else begin
            if (!sync) begin
                if (prev_sync) begin
                    cur.ch = int'(cur_ch);
                    cur.word = '0;
                    cur.falls = 0;
                    cur.low = 0;
                end
                cur.low++;
                if (prev_sclk && !sclk) begin
                    cur.word = {cur.word[62:0], sdi};
                    cur.falls++;
                end
            end else if (!prev_sync) begin
                got_q.push_back(cur);
            end else if (prev_sclk != sclk) begin
                stray++;
            end
            prev_sync = sync;
            prev_sclk = sclk;
        end
    end

    // Same capture for the wide, fast-clocked instance.
    logic prev_sync2 = 1'b1;
    logic prev_sclk2 = 1'b1;
    frame_t cur2;
    always @(negedge clk) begin
        if (rst) begin
            prev_sync2 = 1'b1;
            prev_sclk2 = 1'b1;
        end else begin
            if (!sync2) begin
                if (prev_sync2) begin
                    cur2.ch = int'(cur_ch2);
                    cur2.word = '0;
                    cur2.falls = 0;
                    cur2.low = 0;
                end
                cur2.low++;
                if (prev_sclk2 && !sclk2) begin
                    cur2.word = {cur2.word[62:0], sdi2};
                    cur2.falls++;
                end
            end else if (!prev_sync2) begin
                got2_q.push_back(cur2);
            end
            prev_sync2 = sync2;
            prev_sclk2 = sclk2;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Expected on-wire word for a channel: data, optionally preceded by 0x3n.
    function automatic logic [63:0] exp_word(input int ch, input logic [63:0] data, input int dw);
        logic [63:0] w;
        w = data;
`ifdef DAC_ADDR_PREFIX_EN
        w = w | (64'(48 + ch) << dw);
`endif
        return w;
    endfunction

    // Reference: one frame per set mask bit, ascending channel order.
    task automatic build_expected(input logic [31:0] d, input logic [1:0] m);
        frame_t f;
        exp_q.delete();
        for (int k = 0; k < CH_N; k++) begin
            if (m[k]) begin
                f.ch = k;
                f.word = exp_word(k, 64'(d[k*DATA_W +: DATA_W]), DATA_W);
                f.falls = FRAME_BITS;
                f.low = FRAME_CYC;
                exp_q.push_back(f);
            end
        end
    endtask

    task automatic compare_frames();
        checkOutput("frame_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checkOutput("frame_ch", 64'(got_q[i].ch), 64'(exp_q[i].ch));
            checkOutput("frame_word", got_q[i].word, exp_q[i].word);
            checkOutput("frame_falls", 64'(got_q[i].falls), 64'(exp_q[i].falls));
            checkOutput("frame_sync_low", 64'(got_q[i].low), 64'(exp_q[i].low));
        end
    endtask

    // One request: launch (unless already launched in the previous FIN cycle),
    // optionally poke extra starts while busy, wait for done and check it;
    // optionally launch the next request in the FIN cycle.
    task automatic applyStimulus(input logic [31:0] d, input logic [1:0] m, input bit already,
                                 input bit poke, input bit chain,
                                 input logic [31:0] nd, input logic [1:0] nm);
        int k;
        int extra;
        bit got;
        got_q.delete();
        if (!already) begin
            @(negedge clk);
            dato = d;
            ch_mask = m;
            start = 1'b1;
        end
        build_expected(d, m);
        k = 0;
        got = 1'b0;
        while (!got && k < WAIT_LIMIT) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (poke && (k == 10 || k == 68)) begin
                start = 1'b1;
                dato = ~d;
                ch_mask = 2'b11;
            end
            if (k == 1) checkOutput("busy_after_accept", 64'(busy), 64'd1);
            if (done) got = 1'b1;
        end
        checkOutput("done_latency", 64'(k), 64'(3 + exp_q.size() * (FRAME_CYC + GAP_CYC)));
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        compare_frames();
        if (chain) begin
            dato = nd;
            ch_mask = nm;
            start = 1'b1;
        end else begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("done_one_cycle", 64'(done), 64'd0);
            if (poke) begin
                extra = 0;
                repeat (150) begin
                    @(negedge clk);
                    if (done || busy) extra++;
                end
                checkOutput("no_queued_request", 64'(extra), 64'd0);
            end
        end
    endtask

    vec_t vectors[4];
    logic [31:0] cur_d, nd;
    logic [1:0] cur_m, nm;
    bit pend, ch_next;
    int k2;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dato = '0;
        ch_mask = '0;
        start2 = 1'b0;
        dato2 = '0;
        mask2 = '0;

        vectors[0] = '{32'h1234CAAA, 2'b11, 2, 0};
        vectors[1] = '{32'h1234CAAA, 2'b10, 1, 1};
        vectors[2] = '{32'h1234CAAA, 2'b00, 0, 0};
        vectors[3] = '{32'hBEEF0001, 2'b01, 1, 0};

        repeat (3) @(negedge clk);
        checkOutput("reset_sync", 64'(sync), 64'd1);
        checkOutput("reset_sclk", 64'(sclk), 64'd1);
        checkOutput("reset_sdi", 64'(sdi), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_cur_ch", 64'(cur_ch), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] vector table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vectors[i].dato, vectors[i].mask, 1'b0, 1'b0, 1'b0, '0, '0);
            checkOutput("tbl_frames", 64'(got_q.size()), 64'(vectors[i].exp_frames));
            if (got_q.size() > 0)
                checkOutput("tbl_first_ch", 64'(got_q[0].ch), 64'(vectors[i].exp_first_ch));
        end

        $display("[TB] starts while busy are ignored");
        applyStimulus(32'h1234CAAA, 2'b11, 1'b0, 1'b1, 1'b0, '0, '0);

        $display("[TB] start in FIN cycle is accepted");
        applyStimulus(32'h1234CAAA, 2'b11, 1'b0, 1'b0, 1'b1, 32'h5A5AA5A5, 2'b10);
        applyStimulus(32'h5A5AA5A5, 2'b10, 1'b1, 1'b0, 1'b0, '0, '0);

        $display("[TB] reset in the middle of bit 7");
        @(negedge clk);
        dato = 32'h1234CAAA;
        ch_mask = 2'b01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        checkOutput("mid_frame_sync_low", 64'(sync), 64'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_mid_sync", 64'(sync), 64'd1);
        checkOutput("rst_mid_sclk", 64'(sclk), 64'd1);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(32'h1234CAAA, 2'b01, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] random requests");
        cur_d = $urandom;
        cur_m = 2'($urandom_range(0, 3));
        pend = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nd = $urandom;
            nm = 2'($urandom_range(0, 3));
            ch_next = ($urandom_range(0, 1) == 1) && (i < 19);
            applyStimulus(cur_d, cur_m, pend, 1'b0, ch_next, nd, nm);
            if (ch_next) begin
                cur_d = nd;
                cur_m = nm;
                pend = 1'b1;
            end else begin
                cur_d = $urandom;
                cur_m = 2'($urandom_range(0, 3));
                pend = 1'b0;
            end
        end
        checkOutput("stray_sclk", 64'(stray), 64'd0);

        $display("[TB] DATA_W=24 CH_N=4 CLK_DIV=1 instance");
        got2_q.delete();
        @(negedge clk);
        dato2 = '1;
        mask2 = 4'hF;
        start2 = 1'b1;
        k2 = 0;
        while (k2 < WAIT_LIMIT) begin
            @(negedge clk);
            k2++;
            start2 = 1'b0;
            if (done2) break;
        end
        checkOutput("d2_latency", 64'(k2), 64'(3 + D2_CH * (D2_FRAME_CYC + GAP_CYC)));
        checkOutput("d2_frames", 64'(got2_q.size()), 64'(D2_CH));
        for (int i = 0; i < got2_q.size() && i < D2_CH; i++) begin
            checkOutput("d2_ch", 64'(got2_q[i].ch), 64'(i));
            checkOutput("d2_sync_low", 64'(got2_q[i].low), 64'(D2_FRAME_CYC));
            checkOutput("d2_falls", 64'(got2_q[i].falls), 64'(D2_FRAME_BITS));
            checkOutput("d2_word", got2_q[i].word, exp_word(i, 64'hFFFFFF, D2_W));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
